// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and defaults for the execute-path operand logic.
package riscv_pipe_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_src_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/alu_operand_stage_fwd_resolve.sv
// Combinational RAW-forwarding resolver for one source register.
module fwd_resolve #(
  parameter int XLEN       = riscv_pipe_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rdata,
  input  logic                  exmem_wr_en,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_data,
  input  logic                  memwb_wr_en,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_data,
  output logic [XLEN-1:0]       rs_data,
  output logic [1:0]            src
);
  import riscv_pipe_pkg::*;

  logic is_zero;
  logic exmem_hit;
  logic memwb_hit;

  // A writer targeting x0 never forwards, and reading x0 always yields zero.
  assign is_zero   = (rs_addr == REG_ADDR_W'(REG_ZERO));
  assign exmem_hit = exmem_wr_en && (exmem_rd == rs_addr) && !is_zero;
  assign memwb_hit = memwb_wr_en && (memwb_rd == rs_addr) && !is_zero;

  always_comb begin
    rs_data = rdata;
    src     = FWD_RF;
    if (is_zero) begin
      rs_data = '0;
    end else if (exmem_hit) begin
      rs_data = exmem_data;
      src     = FWD_EXMEM;
    end else if (memwb_hit) begin
      rs_data = memwb_data;
      src     = FWD_MEMWB;
    end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand resolution with forwarding and an ID/EX-style output register.
// Optional forwarding counters are enabled by defining FWD_STATS_EN.
module alu_operand_stage #(
  parameter int XLEN       = riscv_pipe_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rdata1,
  input  logic [XLEN-1:0]       rdata2,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       pc,
  input  logic                  sel_a_pc,
  input  logic                  sel_b_imm,
  input  logic                  exmem_wr_en,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_data,
  input  logic                  memwb_wr_en,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  output logic [XLEN-1:0]       store_data
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]           fwd_exmem_cnt,
  output logic [31:0]           fwd_memwb_cnt
`endif
);
  import riscv_pipe_pkg::*;

  logic [XLEN-1:0] rs1_p0, rs2_p0;
  logic [1:0]      src1_p0, src2_p0;
  logic [XLEN-1:0] op_a_p0, op_b_p0;
  logic [XLEN-1:0] op_a_p1, op_b_p1, store_p1;
  logic            vld_p1;
  logic            load;

  fwd_resolve #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr(rs1_addr), .rdata(rdata1),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .rs_data(rs1_p0), .src(src1_p0)
  );

  fwd_resolve #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr(rs2_addr), .rdata(rdata2),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .rs_data(rs2_p0), .src(src2_p0)
  );

  // rs1 is resolved regardless of sel_a_pc; only the final mux picks the PC.
  assign op_a_p0 = sel_a_pc  ? pc  : rs1_p0;
  assign op_b_p0 = sel_b_imm ? imm : rs2_p0;

  assign in_ready = !vld_p1 || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // ---- p0 -> p1: output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      op_a_p1  <= '0;
      op_b_p1  <= '0;
      store_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      op_a_p1  <= op_a_p0;
      op_b_p1  <= op_b_p0;
      store_p1 <= rs2_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign op_a       = op_a_p1;
  assign op_b       = op_b_p1;
  assign store_data = store_p1;

  x0_never_forwards: assert property (@(posedge clk) disable iff (!rst_n)
    ((rs1_addr != '0) || (src1_p0 == FWD_RF)) && ((rs2_addr != '0) || (src2_p0 == FWD_RF)));

`ifdef FWD_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [1:0] exmem_hits, memwb_hits;
  assign exmem_hits = {1'b0, src1_p0 == FWD_EXMEM} + {1'b0, src2_p0 == FWD_EXMEM};
  assign memwb_hits = {1'b0, src1_p0 == FWD_MEMWB} + {1'b0, src2_p0 == FWD_MEMWB};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_exmem_cnt <= '0;
      fwd_memwb_cnt <= '0;
    end else if (load) begin
      fwd_exmem_cnt <= sat_add(fwd_exmem_cnt, exmem_hits);
      fwd_memwb_cnt <= sat_add(fwd_memwb_cnt, memwb_hits);
    end
  end
`endif
endmodule
